analog_axis_emu: RTL and testbench

//  Parametrised paddle/analog-axis source for console cores. Merges a PS/2 mouse
//  (relative deltas accumulated into saturating signed axes) with a host analog

---
 rtl/analog_axis_emu.sv | 190 +++++++++++++++++++
 tb/tb_analog_axis_emu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/analog_axis_emu.sv
// Paddle/analog-axis source: merges PS/2 mouse deltas (saturating accumulators)
// with a host analog joystick, with mode select, auto-detect and optional decay.
module analog_axis_emu #(
  parameter int W       = 8,
  parameter int MAXSTEP = 10,
  parameter int SENS_SH = 0
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic [24:0]  ps2_mouse,
  input  logic [W-1:0] joy_ax,
  input  logic [W-1:0] joy_ay,
  input  logic [1:0]   joy_btn,
  input  logic [1:0]   mode,
  input  logic         decay_ce,
  output logic [W-1:0] ax_out,
  output logic [W-1:0] ay_out,
  output logic [1:0]   btn_out,
  output logic         src_mouse,
  output logic         upd
);

  localparam int AW = (W + 2 > 10) ? W + 2 : 10;
  localparam logic signed [AW-1:0] ACC_MAX  = AW'((2 ** (W - 1)) - 1);
  localparam logic signed [AW-1:0] ACC_MIN  = ~ACC_MAX;
  localparam logic signed [AW-1:0] STEP_MAX = AW'(MAXSTEP);
  localparam logic signed [AW-1:0] STEP_MIN = -STEP_MAX;

  localparam logic [1:0] MODE_AUTO  = 2'b00;
  localparam logic [1:0] MODE_JOY   = 2'b01;
  localparam logic [1:0] MODE_MOUSE = 2'b10;
  localparam logic [1:0] MODE_DECAY = 2'b11;

  function automatic logic signed [AW-1:0] mouse_delta(input logic sgn, input logic [7:0] mag);
    logic signed [AW-1:0] d;
    d = {{(AW - 8){sgn}}, mag};
    d = d >>> SENS_SH;
    if (d > STEP_MAX) begin
      d = STEP_MAX;
    end else if (d < STEP_MIN) begin
      d = STEP_MIN;
    end else begin
      d = d;
    end
    return d;
  endfunction

  function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] d);
    logic signed [AW-1:0] s;
    s = a + d;
    if (s > ACC_MAX) begin
      s = ACC_MAX;
    end else if (s < ACC_MIN) begin
      s = ACC_MIN;
    end else begin
      s = s;
    end
    return s;
  endfunction

  function automatic logic signed [AW-1:0] toward_zero(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] r;
    if (a[AW-1]) begin
      r = a + AW'(1);
    end else if (a != '0) begin
      r = a - AW'(1);
    end else begin
      r = a;
    end
    return r;
  endfunction

  logic signed [AW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic                 src_q, src_d;
  logic                 old_stb_q, old_stb_d;
  logic [1:0]           prev_mode_q, prev_mode_d;
  logic [W-1:0]         ax_q, ax_d, ay_q, ay_d;
  logic [1:0]           btn_q, btn_d;
  logic                 upd_q, upd_d;

  logic                 evt_s;
  logic                 mode_chg_s;
  logic                 joy_active_s;
  logic signed [AW-1:0] dx_s, dy_s;
  logic                 unused_bits_s;

  assign evt_s         = ps2_mouse[24] ^ old_stb_q;
  assign mode_chg_s    = (mode != prev_mode_q);
  assign joy_active_s  = (joy_ax != '0) || (joy_ay != '0);
  assign dx_s          = mouse_delta(ps2_mouse[4], ps2_mouse[15:8]);
  assign dy_s          = mouse_delta(ps2_mouse[5], ps2_mouse[23:16]);
  assign unused_bits_s = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  always_comb begin
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    src_d       = src_q;
    old_stb_d   = ps2_mouse[24];
    prev_mode_d = mode;
    if (mode_chg_s) begin
      acc_x_d = '0;
      acc_y_d = '0;
      src_d   = mode[1];
    end else begin
      case (mode)
        MODE_AUTO: begin
          // joystick activity beats a mouse event in the same cycle
          if (joy_active_s) begin
            src_d   = 1'b0;
            acc_x_d = '0;
            acc_y_d = '0;
          end else if (evt_s) begin
            src_d   = 1'b1;
            acc_x_d = sat_add(acc_x_q, dx_s);
            acc_y_d = sat_add(acc_y_q, dy_s);
          end else begin
            src_d = src_q;
          end
        end
        MODE_JOY: begin
          src_d   = 1'b0;
          acc_x_d = '0;
          acc_y_d = '0;
        end
        MODE_MOUSE: begin
          src_d = 1'b1;
          if (evt_s) begin
            acc_x_d = sat_add(acc_x_q, dx_s);
            acc_y_d = sat_add(acc_y_q, dy_s);
          end else begin
            acc_x_d = acc_x_q;
          end
        end
        MODE_DECAY: begin
          src_d = 1'b1;
          if (evt_s) begin
            acc_x_d = sat_add(acc_x_q, dx_s);
            acc_y_d = sat_add(acc_y_q, dy_s);
          end else if (decay_ce) begin
            acc_x_d = toward_zero(acc_x_q);
            acc_y_d = toward_zero(acc_y_q);
          end else begin
            acc_x_d = acc_x_q;
          end
        end
        default: begin
          src_d = src_q;
        end
      endcase
    end

    ax_d  = src_d ? acc_x_d[W-1:0] : joy_ax;
    ay_d  = src_d ? acc_y_d[W-1:0] : joy_ay;
    btn_d = src_d ? ps2_mouse[1:0] : joy_btn;
    upd_d = (ax_d != ax_q) || (ay_d != ay_q) || (btn_d != btn_q);
  end

  // State and output registers; reset re-arms the strobe so no event follows release
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      src_q       <= 1'b0;
      old_stb_q   <= ps2_mouse[24];
      prev_mode_q <= mode;
      ax_q        <= '0;
      ay_q        <= '0;
      btn_q       <= 2'b00;
      upd_q       <= 1'b0;
    end else begin
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      src_q       <= src_d;
      old_stb_q   <= old_stb_d;
      prev_mode_q <= prev_mode_d;
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      btn_q       <= btn_d;
      upd_q       <= upd_d;
    end
  end

  assign ax_out    = ax_q;
  assign ay_out    = ay_q;
  assign btn_out   = btn_q;
  assign src_mouse = src_q;
  assign upd       = upd_q;

endmodule

// File: tb/tb_analog_axis_emu.sv
// Self-checking bench for analog_axis_emu: integer behavioural model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_analog_axis_emu;

  localparam int W = 8;
  localparam int MAXSTEP = 10;
  localparam int SENS_SH = 0;
  localparam int AMAX = 127;
  localparam int AMIN = -128;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [24:0]  ps2_mouse;
  logic [W-1:0] joy_ax, joy_ay;
  logic [1:0]   joy_btn, mode;
  logic         decay_ce;
  logic [W-1:0] ax_out, ay_out;
  logic [1:0]   btn_out;
  logic         src_mouse, upd;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // model state
  int         m_ax, m_ay;
  bit         m_src, m_old;
  logic [1:0] m_prev;
  logic [7:0] e_ax = 8'h00, e_ay = 8'h00;
  logic [1:0] e_btn = 2'b00;
  bit         e_upd = 1'b0;

  analog_axis_emu #(.W(W), .MAXSTEP(MAXSTEP), .SENS_SH(SENS_SH)) dut (
    .clk_sys(clk), .reset_n(reset_n), .ps2_mouse(ps2_mouse),
    .joy_ax(joy_ax), .joy_ay(joy_ay), .joy_btn(joy_btn),
    .mode(mode), .decay_ce(decay_ce),
    .ax_out(ax_out), .ay_out(ay_out), .btn_out(btn_out),
    .src_mouse(src_mouse), .upd(upd)
  );

  always #5 clk = ~clk;

  function automatic int delta(input logic sgn, input logic [7:0] mag);
    int d;
    d = sgn ? int'(mag) - 256 : int'(mag);
    d = d >>> SENS_SH;
    if (d > MAXSTEP) d = MAXSTEP;
    if (d < -MAXSTEP) d = -MAXSTEP;
    return d;
  endfunction

  function automatic int sat(input int v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  function automatic int decay1(input int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return v;
  endfunction

  // reference model, evaluated on the same edge as the DUT
  always @(posedge clk) begin
    logic [7:0] n_ax, n_ay;
    logic [1:0] n_btn;
    bit evt;
    if (!reset_n) begin
      m_ax = 0; m_ay = 0; m_src = 1'b0;
      m_old = ps2_mouse[24]; m_prev = mode;
      e_ax = 8'h00; e_ay = 8'h00; e_btn = 2'b00; e_upd = 1'b0;
    end else begin
      evt = (ps2_mouse[24] != m_old);
      m_old = ps2_mouse[24];
      if (mode != m_prev) begin
        m_ax = 0; m_ay = 0;
        m_src = (mode == 2'b10) || (mode == 2'b11);
      end else if (mode == 2'b00) begin
        if (joy_ax != 8'h00 || joy_ay != 8'h00) begin
          m_src = 1'b0; m_ax = 0; m_ay = 0;
        end else if (evt) begin
          m_src = 1'b1;
          m_ax = sat(m_ax + delta(ps2_mouse[4], ps2_mouse[15:8]));
          m_ay = sat(m_ay + delta(ps2_mouse[5], ps2_mouse[23:16]));
        end
      end else if (mode == 2'b01) begin
        m_src = 1'b0; m_ax = 0; m_ay = 0;
      end else begin
        m_src = 1'b1;
        if (evt) begin
          m_ax = sat(m_ax + delta(ps2_mouse[4], ps2_mouse[15:8]));
          m_ay = sat(m_ay + delta(ps2_mouse[5], ps2_mouse[23:16]));
        end else if (mode == 2'b11 && decay_ce) begin
          m_ax = decay1(m_ax);
          m_ay = decay1(m_ay);
        end
      end
      m_prev = mode;
      n_ax  = m_src ? m_ax[7:0] : joy_ax;
      n_ay  = m_src ? m_ay[7:0] : joy_ay;
      n_btn = m_src ? ps2_mouse[1:0] : joy_btn;
      e_upd = (n_ax != e_ax) || (n_ay != e_ay) || (n_btn != e_btn);
      e_ax = n_ax; e_ay = n_ay; e_btn = n_btn;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("ax_out", 32'(ax_out), 32'(e_ax));
      check("ay_out", 32'(ay_out), 32'(e_ay));
      check("btn_out", 32'(btn_out), 32'(e_btn));
      check("src_mouse", 32'(src_mouse), 32'(m_src));
      check("upd", 32'(upd), 32'(e_upd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mouse_evt(input int dx, input int dy, input logic [1:0] b);
    logic [24:0] w;
    w = ps2_mouse;
    w[24] = ~w[24];
    w[15:8] = dx[7:0];
    w[23:16] = dy[7:0];
    w[4] = (dx < 0);
    w[5] = (dy < 0);
    w[1:0] = b;
    ps2_mouse = w;
  endtask

  initial begin
    logic [7:0] x_seq[5];
    logic [7:0] y_seq[5];
    x_seq = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    y_seq = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};

    reset_n = 1'b0; ps2_mouse = 25'h1000000;
    joy_ax = 8'h00; joy_ay = 8'h00; joy_btn = 2'b00;
    mode = 2'b00; decay_ce = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    check("rel_no_evt_ax", 32'(ax_out), 32'h00);
    check("rel_no_evt_upd", 32'(upd), 32'h0);
    check("rel_no_evt_src", 32'(src_mouse), 32'h0);

    mouse_evt(3, 0, 2'b00); tick();
    check("evt_p3_ax", 32'(ax_out), 32'h03);
    check("evt_p3_src", 32'(src_mouse), 32'h1);
    check("evt_p3_upd", 32'(upd), 32'h1);
    tick();
    check("upd_one_cycle", 32'(upd), 32'h0);

    mouse_evt(-200, 0, 2'b00); tick();
    check("clamp_neg", 32'(ax_out), 32'hF9);
    repeat (15) begin mouse_evt(10, 0, 2'b00); tick(); end
    check("sat_pos", 32'(ax_out), 32'h7F);
    mouse_evt(10, 0, 2'b00); tick();
    check("sat_hold", 32'(ax_out), 32'h7F);
    check("sat_hold_upd", 32'(upd), 32'h0);

    joy_ax = 8'h40; mouse_evt(5, 5, 2'b11); tick();
    check("joy_wins_ax", 32'(ax_out), 32'h40);
    check("joy_wins_src", 32'(src_mouse), 32'h0);
    joy_ax = 8'h00;

    mode = 2'b11; tick();
    check("mode11_chg_ax", 32'(ax_out), 32'h00);
    mouse_evt(5, -2, 2'b00); tick();
    check("mode11_ax5", 32'(ax_out), 32'h05);
    check("mode11_ayn2", 32'(ay_out), 32'hFE);
    decay_ce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("decay_x", 32'(ax_out), 32'(x_seq[i]));
      check("decay_y", 32'(ay_out), 32'(y_seq[i]));
    end
    mouse_evt(3, 0, 2'b00); tick();
    check("decay_skipped", 32'(ax_out), 32'h03);
    decay_ce = 1'b0;

    mode = 2'b01; joy_ax = 8'h20; joy_btn = 2'b01; tick();
    for (int i = 0; i < 4; i++) begin mouse_evt(7, 7, 2'b10); tick(); end
    check("mode01_ax", 32'(ax_out), 32'h20);
    check("mode01_btn", 32'(btn_out), 32'h1);
    check("mode01_src", 32'(src_mouse), 32'h0);

    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        mouse_evt($urandom_range(0, 511) - 256, $urandom_range(0, 511) - 256,
                  2'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) begin
        joy_ax = 8'($urandom_range(0, 255));
        joy_ay = 8'($urandom_range(0, 255));
      end else begin
        joy_ax = 8'h00; joy_ay = 8'h00;
      end
      joy_btn = 2'($urandom_range(0, 3));
      decay_ce = ($urandom_range(0, 3) == 0);
      tick();
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
